// File: rtl/instr_fetch_stage.sv
// rtl/instr_fetch_stage.sv - fetch stage with PC, imem handshake, skid buffer and IF/ID register
module instr_fetch_stage #(
  parameter int                XLEN      = 32,
  parameter logic [XLEN-1:0]   RESET_PC  = '0,
  parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  input  logic            stall_d,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            valid_d,
  output logic [6:0]      Op,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [31:0]     instr_count
);

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [XLEN-1:0]   pcd_q, pcd_d;
  logic [XLEN-1:0]   pcp4_q, pcp4_d;
  logic              dvalid_q, dvalid_d;
  logic [31:0]       count_q, count_d;
  logic [31:0]       skid_instr_q, skid_instr_d;
  logic [XLEN-1:0]   skid_pc_q, skid_pc_d;

  logic              slot_free;
  logic              fire;
  logic [XLEN-1:0]   pc_plus4;
  logic [XLEN-1:0]   skid_pc_plus4;
  logic              unused_target_bits;

  assign unused_target_bits = ^PCTarget[1:0];

  // Request is a pure function of state (and reset), never of imem_ready.
  assign imem_req      = (state_q == S_FETCH) && !rst;
  assign imem_addr     = pc_q;
  assign fire          = imem_req && imem_ready;
  assign slot_free     = !dvalid_q || !stall_d;
  assign pc_plus4      = pc_q + XLEN'(4);
  assign skid_pc_plus4 = skid_pc_q + XLEN'(4);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pcd_d        = pcd_q;
    pcp4_d       = pcp4_q;
    dvalid_d     = dvalid_q;
    count_d      = count_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    if (PCSrc) begin
      // Redirect beats everything: drop the returning word and any skid contents.
      pc_d     = {PCTarget[XLEN-1:2], 2'b00};
      instr_d  = NOP_INSTR;
      dvalid_d = 1'b0;
      state_d  = S_FETCH;
    end else begin
      if (dvalid_q && !stall_d) begin
        dvalid_d = 1'b0;
      end
      case (state_q)
        S_FETCH: begin
          if (fire) begin
            pc_d = pc_plus4;
            if (slot_free) begin
              instr_d  = imem_rdata;
              pcd_d    = pc_q;
              pcp4_d   = pc_plus4;
              dvalid_d = 1'b1;
              count_d  = count_q + 32'd1;
            end else begin
              skid_instr_d = imem_rdata;
              skid_pc_d    = pc_q;
              state_d      = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (slot_free) begin
            instr_d  = skid_instr_q;
            pcd_d    = skid_pc_q;
            pcp4_d   = skid_pc_plus4;
            dvalid_d = 1'b1;
            count_d  = count_q + 32'd1;
            state_d  = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INSTR;
      pcd_q        <= '0;
      pcp4_q       <= '0;
      dvalid_q     <= 1'b0;
      count_q      <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pcd_q        <= pcd_d;
      pcp4_q       <= pcp4_d;
      dvalid_q     <= dvalid_d;
      count_q      <= count_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign InstrD      = instr_q;
  assign PCD         = pcd_q;
  assign PCPlus4D    = pcp4_q;
  assign valid_d     = dvalid_q;
  assign instr_count = count_q;

  assign Op     = instr_q[6:0];
  assign funct3 = instr_q[14:12];
  assign funct7 = instr_q[31:25];

endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb/tb_instr_fetch_stage.sv - directed vector bench for instr_fetch_stage
module tb_instr_fetch_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] W1   = 32'h0050_0093;
  localparam logic [31:0] W2   = 32'h00A0_0113;
  localparam logic [31:0] W3   = 32'h0030_8193;
  localparam logic [31:0] W4   = 32'h0041_0213;
  localparam logic [31:0] W5   = 32'h0051_0293;
  localparam logic [31:0] W6   = 32'h40A0_D2B3;
  localparam logic [31:0] W7   = 32'h0000_0033;
  localparam logic [31:0] W8   = 32'h0010_0093;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall_d;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        valid_d;
  logic [6:0]  Op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] instr_count;

  int passed;
  int total;

  instr_fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .stall_d     (stall_d),
    .PCSrc       (PCSrc),
    .PCTarget    (PCTarget),
    .InstrD      (InstrD),
    .PCD         (PCD),
    .PCPlus4D    (PCPlus4D),
    .valid_d     (valid_d),
    .Op          (Op),
    .funct3      (funct3),
    .funct7      (funct7),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic [31:0] rdata;
    logic        stall;
    logic        pcsrc;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic        chk_pc;
    logic [31:0] e_pcd;
    logic [31:0] e_pcp4;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vec [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 time unit later.
  task automatic step(input logic r, input logic rdy, input logic [31:0] rd,
                      input logic st, input logic ps, input logic [31:0] tg);
    @(negedge clk);
    rst        = r;
    imem_ready = rdy;
    imem_rdata = rd;
    stall_d    = st;
    PCSrc      = ps;
    PCTarget   = tg;
    #1;
  endtask

  initial begin
    passed     = 0;
    total      = 0;
    rst        = 1'b1;
    imem_ready = 1'b0;
    imem_rdata = '0;
    stall_d    = 1'b0;
    PCSrc      = 1'b0;
    PCTarget   = '0;

    //          rst   rdy   rdata stall pcsrc tgt       | req   addr       valid instr chk   pcd     pcp4    cnt
    vec[0]  = '{1'b1, 1'b0, JUNK, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0,     1'b0, NOP, 1'b1, 32'h0,  32'h0,  32'd0};
    vec[1]  = '{1'b0, 1'b1, W1,   1'b0, 1'b0, 32'h0,     1'b1, 32'h0,     1'b0, NOP, 1'b1, 32'h0,  32'h0,  32'd0};
    vec[2]  = '{1'b0, 1'b1, W2,   1'b0, 1'b0, 32'h0,     1'b1, 32'h4,     1'b1, W1,  1'b1, 32'h0,  32'h4,  32'd1};
    vec[3]  = '{1'b0, 1'b0, JUNK, 1'b0, 1'b0, 32'h0,     1'b1, 32'h8,     1'b1, W2,  1'b1, 32'h4,  32'h8,  32'd2};
    vec[4]  = '{1'b0, 1'b0, JUNK, 1'b0, 1'b0, 32'h0,     1'b1, 32'h8,     1'b0, W2,  1'b1, 32'h4,  32'h8,  32'd2};
    vec[5]  = '{1'b0, 1'b0, JUNK, 1'b0, 1'b0, 32'h0,     1'b1, 32'h8,     1'b0, W2,  1'b1, 32'h4,  32'h8,  32'd2};
    vec[6]  = '{1'b0, 1'b1, W3,   1'b0, 1'b0, 32'h0,     1'b1, 32'h8,     1'b0, W2,  1'b1, 32'h4,  32'h8,  32'd2};
    vec[7]  = '{1'b0, 1'b1, W4,   1'b1, 1'b0, 32'h0,     1'b1, 32'hC,     1'b1, W3,  1'b1, 32'h8,  32'hC,  32'd3};
    vec[8]  = '{1'b0, 1'b1, JUNK, 1'b1, 1'b0, 32'h0,     1'b0, 32'h10,    1'b1, W3,  1'b1, 32'h8,  32'hC,  32'd3};
    vec[9]  = '{1'b0, 1'b1, JUNK, 1'b0, 1'b0, 32'h0,     1'b0, 32'h10,    1'b1, W3,  1'b1, 32'h8,  32'hC,  32'd3};
    vec[10] = '{1'b0, 1'b0, JUNK, 1'b0, 1'b0, 32'h0,     1'b1, 32'h10,    1'b1, W4,  1'b1, 32'hC,  32'h10, 32'd4};
    vec[11] = '{1'b0, 1'b1, W5,   1'b0, 1'b1, 32'h103,   1'b1, 32'h10,    1'b0, W4,  1'b1, 32'hC,  32'h10, 32'd4};
    vec[12] = '{1'b0, 1'b0, JUNK, 1'b0, 1'b0, 32'h0,     1'b1, 32'h100,   1'b0, NOP, 1'b0, 32'h0,  32'h0,  32'd4};

    for (int i = 0; i < 13; i++) begin
      step(vec[i].rst, vec[i].rdy, vec[i].rdata, vec[i].stall, vec[i].pcsrc, vec[i].tgt);
      chk($sformatf("v%0d imem_req", i), {31'd0, imem_req}, {31'd0, vec[i].e_req});
      chk($sformatf("v%0d imem_addr", i), imem_addr, vec[i].e_addr);
      chk($sformatf("v%0d valid_d", i), {31'd0, valid_d}, {31'd0, vec[i].e_valid});
      chk($sformatf("v%0d InstrD", i), InstrD, vec[i].e_instr);
      chk($sformatf("v%0d instr_count", i), instr_count, vec[i].e_cnt);
      if (vec[i].chk_pc) begin
        chk($sformatf("v%0d PCD", i), PCD, vec[i].e_pcd);
        chk($sformatf("v%0d PCPlus4D", i), PCPlus4D, vec[i].e_pcp4);
      end
    end
    chk("nop Op", {25'd0, Op}, 32'h13);

    // Decoder slices on an R-type word, then reset asserted asynchronously mid-HOLD.
    step(1'b0, 1'b1, W6, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, W7, 1'b1, 1'b0, 32'h0);
    chk("sra InstrD", InstrD, W6);
    chk("sra Op", {25'd0, Op}, 32'h33);
    chk("sra funct3", {29'd0, funct3}, 32'h5);
    chk("sra funct7", {25'd0, funct7}, 32'h20);
    chk("sra PCD", PCD, 32'h100);
    chk("sra PCPlus4D", PCPlus4D, 32'h104);
    chk("sra count", instr_count, 32'd5);
    step(1'b0, 1'b1, JUNK, 1'b1, 1'b0, 32'h0);
    chk("hold req", {31'd0, imem_req}, 32'd0);
    chk("hold addr", imem_addr, 32'h108);
    chk("hold InstrD", InstrD, W6);
    #2 rst = 1'b1;
    #1;
    chk("arst req", {31'd0, imem_req}, 32'd0);
    chk("arst addr", imem_addr, 32'h0);
    chk("arst valid", {31'd0, valid_d}, 32'd0);
    chk("arst InstrD", InstrD, NOP);
    chk("arst PCD", PCD, 32'h0);
    chk("arst PCPlus4D", PCPlus4D, 32'h0);
    chk("arst count", instr_count, 32'd0);
    chk("arst Op", {25'd0, Op}, 32'h13);
    chk("arst funct3", {29'd0, funct3}, 32'h0);
    chk("arst funct7", {25'd0, funct7}, 32'h0);
    step(1'b0, 1'b0, JUNK, 1'b0, 1'b0, 32'h0);
    chk("restart req", {31'd0, imem_req}, 32'd1);
    chk("restart addr", imem_addr, 32'h0);

    // PC wrap at the top of the address space, then flush while stalled.
    step(1'b0, 1'b0, JUNK, 1'b0, 1'b1, 32'hFFFF_FFFF);
    chk("restart valid", {31'd0, valid_d}, 32'd0);
    step(1'b0, 1'b1, W8, 1'b0, 1'b0, 32'h0);
    chk("top addr", imem_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, JUNK, 1'b1, 1'b1, 32'h0000_0202);
    chk("wrap addr", imem_addr, 32'h0);
    chk("wrap PCD", PCD, 32'hFFFF_FFFC);
    chk("wrap PCPlus4D", PCPlus4D, 32'h0);
    chk("wrap InstrD", InstrD, W8);
    chk("wrap count", instr_count, 32'd1);
    step(1'b0, 1'b0, JUNK, 1'b1, 1'b0, 32'h0);
    chk("stallflush valid", {31'd0, valid_d}, 32'd0);
    chk("stallflush InstrD", InstrD, NOP);
    chk("stallflush addr", imem_addr, 32'h200);
    chk("stallflush count", instr_count, 32'd1);

    // Redirect while HOLD must discard the skid word.
    step(1'b0, 1'b1, W1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, W2, 1'b1, 1'b0, 32'h0);
    chk("skid pre InstrD", InstrD, W1);
    chk("skid pre count", instr_count, 32'd2);
    step(1'b0, 1'b0, JUNK, 1'b1, 1'b1, 32'h0000_0300);
    chk("skid hold req", {31'd0, imem_req}, 32'd0);
    step(1'b0, 1'b0, JUNK, 1'b0, 1'b0, 32'h0);
    chk("skid drop addr", imem_addr, 32'h300);
    chk("skid drop req", {31'd0, imem_req}, 32'd1);
    chk("skid drop valid", {31'd0, valid_d}, 32'd0);
    step(1'b0, 1'b0, JUNK, 1'b0, 1'b0, 32'h0);
    chk("skid gone valid", {31'd0, valid_d}, 32'd0);
    chk("skid gone count", instr_count, 32'd2);
    chk("skid gone InstrD", InstrD, NOP);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
